int_ctx_unit: RTL and testbench

- Interrupt context controller. It is the producer side of the flag register's interrupt write port.
- On interrupt entry it saves carry/zero flags, return PC and global-enable state on a small LIFO, then vectors the PC.
- On return from interrupt (reti) it pops the context. It drives iwe/intc_o/intz_o back into the flag register and reloads the PC.
- Sits between the control unit, PC register and flag register.

---
 rtl/int_ctx_pkg.sv | 26 ++
 rtl/ctx_stack.sv | 62 ++++++
 rtl/int_ctx_unit.sv | 128 ++++++++++++
 tb/tb_int_ctx_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/int_ctx_pkg.sv
// int_ctx_pkg
//   Shared types for the interrupt context controller.
//   - state_t : controller state (RUN / ENTER / RETURN)
//   - ctx_t   : one saved interrupt context {gie, carry, zero, return PC}
//   - CTX_PC_W / VECTOR_DEF : default PC width and ISR entry address
package int_ctx_pkg;

  localparam int CTX_PC_W = 10;
  localparam logic [CTX_PC_W-1:0] VECTOR_DEF = 10'h3F0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENTER  = 2'd1,
    RETURN = 2'd2
  } state_t;

  // The context layout is fixed by the package PC width, so the top-level
  // PC_W parameter must stay equal to CTX_PC_W.
  typedef struct packed {
    logic                gie;
    logic                c;
    logic                z;
    logic [CTX_PC_W-1:0] pc;
  } ctx_t;

endpackage

// File: rtl/ctx_stack.sv
// ctx_stack
//   LIFO of saved interrupt contexts.
//   Ports:
//     clkg  in   clock, posedge
//     rst   in   asynchronous active-high reset (clears the pointer only)
//     push  in   store din on top (ignored when full)
//     pop   in   discard top entry (ignored when empty)
//     din   in   context to push
//     dout  out  current top-of-stack entry (undefined when empty)
//     level out  number of stored entries, 0..DEPTH
//     full  out  level == DEPTH
//     empty out  level == 0
module ctx_stack
  import int_ctx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clkg,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  ctx_t                     din,
  output ctx_t                     dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  ctx_t        mem [DEPTH];
  logic [AW:0] sp;
  logic [AW-1:0] top_idx;

  assign full    = (sp == FULL_LVL);
  assign empty   = (sp == '0);
  assign level   = sp;
  // Top entry lives one below the write pointer.
  assign top_idx = sp[AW-1:0] - ONE_IDX;
  assign dout    = mem[top_idx];

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + ONE_LVL;
    end else if (pop && !empty) begin
      sp <= sp - ONE_LVL;
    end
  end

  // Storage carries no reset; only the pointer decides what is valid.
  always_ff @(posedge clkg) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/int_ctx_unit.sv
// int_ctx_unit
//   Interrupt context controller. On a taken interrupt it pushes
//   {gie, carry, zero, return PC}, vectors the PC and clears gie; on reti it
//   pops the context, writes carry/zero back to the flag register and
//   reloads the PC.
//   Ports:
//     clkg, rst            clock (posedge), async active-high reset
//     irq                  level interrupt request
//     instr_done           instruction boundary, interrupts taken only here
//     ei, di, reti         instruction pulses
//     pc_ret               return address to save
//     c_flag, z_flag       current flags
//     irq_ack              1-cycle acknowledge of a taken interrupt
//     pc_load/pc_load_val  1-cycle PC overwrite (value 0 when idle)
//     iwe/intc_o/intz_o    flag register interrupt write port
//     gie                  global interrupt enable
//     in_isr, nest_level   nesting status
//     underflow_err        sticky: reti with empty stack
module int_ctx_unit
  import int_ctx_pkg::*;
#(
  parameter int              PC_W   = CTX_PC_W,
  parameter int              DEPTH  = 4,
  parameter logic [PC_W-1:0] VECTOR = VECTOR_DEF
) (
  input  logic                       clkg,
  input  logic                       rst,
  input  logic                       irq,
  input  logic                       instr_done,
  input  logic                       ei,
  input  logic                       di,
  input  logic                       reti,
  input  logic [PC_W-1:0]            pc_ret,
  input  logic                       c_flag,
  input  logic                       z_flag,
  output logic                       irq_ack,
  output logic                       pc_load,
  output logic [PC_W-1:0]            pc_load_val,
  output logic                       iwe,
  output logic                       intc_o,
  output logic                       intz_o,
  output logic                       gie,
  output logic                       in_isr,
  output logic [$clog2(DEPTH):0]     nest_level,
  output logic                       underflow_err
);

  state_t state;
  ctx_t   push_ctx;
  ctx_t   top_ctx;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;

  assign push_ctx = '{gie: gie, c: c_flag, z: z_flag, pc: pc_ret};

  // reti outranks a simultaneous qualifying irq; both are ignored outside RUN.
  assign pop  = (state == RUN) && reti && !empty;
  assign push = (state == RUN) && !reti && irq && gie && instr_done && !full;

  assign in_isr = !empty;

  ctx_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clkg  (clkg),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_ctx),
    .dout  (top_ctx),
    .level (nest_level),
    .full  (full),
    .empty (empty)
  );

  // Strobes are registered at the trigger edge so they are visible for
  // exactly the ENTER/RETURN cycle that follows.
  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      irq_ack       <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_val   <= '0;
      iwe           <= 1'b0;
      intc_o        <= 1'b0;
      intz_o        <= 1'b0;
      gie           <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      irq_ack     <= 1'b0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      iwe         <= 1'b0;
      case (state)
        RUN: begin
          if (di) begin
            gie <= 1'b0;
          end else if (ei) begin
            gie <= 1'b1;
          end
          if (pop) begin
            state       <= RETURN;
            iwe         <= 1'b1;
            intc_o      <= top_ctx.c;
            intz_o      <= top_ctx.z;
            pc_load     <= 1'b1;
            pc_load_val <= top_ctx.pc;
            gie         <= top_ctx.gie;
          end else if (reti) begin
            underflow_err <= 1'b1;
          end else if (push) begin
            state       <= ENTER;
            irq_ack     <= 1'b1;
            pc_load     <= 1'b1;
            pc_load_val <= VECTOR;
            gie         <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctx_unit.sv
// tb_int_ctx_unit
//   Directed table of per-cycle vectors for int_ctx_unit, followed by
//   hand-written sequences for stack-full and reset-during-ENTER.
module tb_int_ctx_unit;

  logic       clkg;
  logic       rst;
  logic       irq;
  logic       instr_done;
  logic       ei;
  logic       di;
  logic       reti;
  logic [9:0] pc_ret;
  logic       c_flag;
  logic       z_flag;
  logic       irq_ack;
  logic       pc_load;
  logic [9:0] pc_load_val;
  logic       iwe;
  logic       intc_o;
  logic       intz_o;
  logic       gie;
  logic       in_isr;
  logic [2:0] nest_level;
  logic       underflow_err;

  int n_pass;
  int n_total;

  int_ctx_unit dut (
    .clkg          (clkg),
    .rst           (rst),
    .irq           (irq),
    .instr_done    (instr_done),
    .ei            (ei),
    .di            (di),
    .reti          (reti),
    .pc_ret        (pc_ret),
    .c_flag        (c_flag),
    .z_flag        (z_flag),
    .irq_ack       (irq_ack),
    .pc_load       (pc_load),
    .pc_load_val   (pc_load_val),
    .iwe           (iwe),
    .intc_o        (intc_o),
    .intz_o        (intz_o),
    .gie           (gie),
    .in_isr        (in_isr),
    .nest_level    (nest_level),
    .underflow_err (underflow_err)
  );

  initial clkg = 1'b0;
  always #5 clkg = ~clkg;

  // ctl = {irq, instr_done, ei, di, reti}; cz = {c_flag, z_flag}
  // exp = {irq_ack, pc_load, pc_load_val, iwe, intc_o, intz_o, gie,
  //        nest_level, in_isr, underflow_err}
  typedef struct {
    logic [4:0]  ctl;
    logic [9:0]  pc;
    logic [1:0]  cz;
    logic [20:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic logic [20:0] e(logic [1:0] ack_pcl, logic [9:0] val,
                                    logic [3:0] iw_c_z_g, logic [2:0] n,
                                    logic uf);
    return {ack_pcl, val, iw_c_z_g, n, (n != 3'd0), uf};
  endfunction

  function automatic vec_t mk(logic [4:0] ctl, logic [9:0] pc, logic [1:0] cz,
                              logic [20:0] ex);
    vec_t v;
    v.ctl = ctl;
    v.pc  = pc;
    v.cz  = cz;
    v.exp = ex;
    return v;
  endfunction

  function automatic logic [20:0] actual();
    return {irq_ack, pc_load, pc_load_val, iwe, intc_o, intz_o, gie,
            nest_level, in_isr, underflow_err};
  endfunction

  task automatic drive(logic [4:0] ctl, logic [9:0] pc, logic [1:0] cz);
    {irq, instr_done, ei, di, reti} = ctl;
    pc_ret = pc;
    {c_flag, z_flag} = cz;
  endtask

  task automatic tick();
    @(posedge clkg);
    #1;
  endtask

  task automatic check_vec(string nm, logic [20:0] exp);
    logic [20:0] act;
    act = actual();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: outputs got %h expected %h", nm, act, exp);
  endtask

  task automatic check_val(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    drive(5'b00000, 10'h000, 2'b00);

    tbl[0]  = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0000, 3'd0, 1'b0));
    tbl[1]  = mk(5'b00100, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0001, 3'd0, 1'b0));
    tbl[2]  = mk(5'b11000, 10'h045, 2'b10, e(2'b11, 10'h3F0, 4'b0000, 3'd1, 1'b0));
    tbl[3]  = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0000, 3'd1, 1'b0));
    tbl[4]  = mk(5'b00001, 10'h000, 2'b00, e(2'b01, 10'h045, 4'b1101, 3'd0, 1'b0));
    tbl[5]  = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0101, 3'd0, 1'b0));
    tbl[6]  = mk(5'b11000, 10'h045, 2'b10, e(2'b11, 10'h3F0, 4'b0100, 3'd1, 1'b0));
    tbl[7]  = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0100, 3'd1, 1'b0));
    tbl[8]  = mk(5'b00100, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0101, 3'd1, 1'b0));
    tbl[9]  = mk(5'b11000, 10'h3F2, 2'b01, e(2'b11, 10'h3F0, 4'b0100, 3'd2, 1'b0));
    tbl[10] = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0100, 3'd2, 1'b0));
    tbl[11] = mk(5'b00001, 10'h000, 2'b00, e(2'b01, 10'h3F2, 4'b1011, 3'd1, 1'b0));
    tbl[12] = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0011, 3'd1, 1'b0));
    tbl[13] = mk(5'b00001, 10'h000, 2'b00, e(2'b01, 10'h045, 4'b1101, 3'd0, 1'b0));
    tbl[14] = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0101, 3'd0, 1'b0));
    tbl[15] = mk(5'b10000, 10'h050, 2'b11, e(2'b00, 10'h000, 4'b0101, 3'd0, 1'b0));
    tbl[16] = mk(5'b01000, 10'h050, 2'b11, e(2'b00, 10'h000, 4'b0101, 3'd0, 1'b0));
    tbl[17] = mk(5'b00110, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0100, 3'd0, 1'b0));
    tbl[18] = mk(5'b11000, 10'h060, 2'b00, e(2'b00, 10'h000, 4'b0100, 3'd0, 1'b0));
    tbl[19] = mk(5'b00100, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0101, 3'd0, 1'b0));
    tbl[20] = mk(5'b11000, 10'h100, 2'b00, e(2'b11, 10'h3F0, 4'b0100, 3'd1, 1'b0));
    tbl[21] = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0100, 3'd1, 1'b0));
    tbl[22] = mk(5'b00100, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0101, 3'd1, 1'b0));
    tbl[23] = mk(5'b11001, 10'h111, 2'b11, e(2'b01, 10'h100, 4'b1001, 3'd0, 1'b0));
    tbl[24] = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0001, 3'd0, 1'b0));
    tbl[25] = mk(5'b00001, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0001, 3'd0, 1'b1));
    tbl[26] = mk(5'b00000, 10'h000, 2'b00, e(2'b00, 10'h000, 4'b0001, 3'd0, 1'b1));

    tick();
    tick();
    check_vec("reset_state", e(2'b00, 10'h000, 4'b0000, 3'd0, 1'b0));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ctl, tbl[i].pc, tbl[i].cz);
      tick();
      check_vec($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Fill the stack to DEPTH, re-enabling gie inside each ISR.
    for (int k = 0; k < 4; k++) begin
      drive(5'b11000, 10'(k), 2'b00);
      tick();
      check_val($sformatf("fill_ack%0d", k), int'(irq_ack), 1);
      check_val($sformatf("fill_lvl%0d", k), int'(nest_level), k + 1);
      drive(5'b00000, 10'h000, 2'b00);
      tick();
      drive(5'b00100, 10'h000, 2'b00);
      tick();
    end
    check_val("full_gie", int'(gie), 1);
    for (int k = 0; k < 3; k++) begin
      drive(5'b11000, 10'h200, 2'b00);
      tick();
      check_val($sformatf("full_noack%0d", k), int'(irq_ack), 0);
      check_val($sformatf("full_lvl%0d", k), int'(nest_level), 4);
    end
    check_val("uf_sticky", int'(underflow_err), 1);
    drive(5'b00001, 10'h000, 2'b00);
    tick();
    check_val("full_reti_iwe", int'(iwe), 1);
    check_val("full_reti_pc", int'(pc_load_val), 3);
    check_val("full_reti_lvl", int'(nest_level), 3);
    drive(5'b00000, 10'h000, 2'b00);
    tick();

    // Reset asserted in the middle of an ENTER cycle.
    drive(5'b11000, 10'h2AA, 2'b11);
    tick();
    check_val("enter_ack_before_rst", int'(irq_ack), 1);
    drive(5'b00000, 10'h000, 2'b00);
    rst = 1'b1;
    #1;
    check_vec("rst_in_enter", e(2'b00, 10'h000, 4'b0000, 3'd0, 1'b0));
    #2;
    rst = 1'b0;
    tick();
    check_vec("after_rst_idle", e(2'b00, 10'h000, 4'b0000, 3'd0, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
